pcie_lane_scrambler: RTL and testbench

//  Per-lane Gen1/Gen2 TX scrambler, one instance per lane, directly after byte striping.

---
 rtl/pcie_lane_scrambler.sv | 90 +++++++++
 tb/tb_pcie_lane_scrambler.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pcie_lane_scrambler.sv
// Per-lane PCIe Gen1/Gen2 TX scrambler: 16-bit Galois LFSR chained across the
// symbols of one lane word, with COM reseed, SKP hold and K-symbol passthrough.

module pcie_scr_sym (
  input  logic [15:0] lfsr_i,
  input  logic [7:0]  sym_i,
  input  logic        k_i,
  input  logic        scr_en_i,
  output logic [7:0]  sym_o,
  output logic [15:0] lfsr_o
);
  logic [15:0] lfsr_adv;
  logic [7:0]  ks;
  logic        is_com, is_skp;

  // One byte of keystream: bit i of the symbol pairs with the out bit of step i
  always_comb begin
    lfsr_adv = lfsr_i;
    ks       = 8'h00;
    for (int i = 0; i < 8; i++) begin
      ks[i]    = lfsr_adv[15];
      lfsr_adv = {lfsr_adv[14:0], 1'b0} ^ (lfsr_adv[15] ? 16'h0039 : 16'h0000);
    end
  end

  assign is_com = k_i && (sym_i == 8'hBC);
  assign is_skp = k_i && (sym_i == 8'h1C);

  // LFSR advances regardless of scramble_en so the receiver stays in step
  assign lfsr_o = is_com ? 16'hFFFF : (is_skp ? lfsr_i : lfsr_adv);
  assign sym_o  = (!k_i && scr_en_i) ? (sym_i ^ ks) : sym_i;
endmodule

module pcie_lane_scrambler #(
  parameter int LANE_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [LANE_WIDTH-1:0]   data_in,
  input  logic [LANE_WIDTH/8-1:0] k_in,
  input  logic                    valid_in,
  input  logic                    scramble_en,
  output logic [LANE_WIDTH-1:0]   data_out,
  output logic [LANE_WIDTH/8-1:0] k_out,
  output logic                    valid_out
);
  localparam int NSYM = LANE_WIDTH / 8;

  logic [NSYM:0][15:0]  lfsr_chain;
  logic [NSYM-1:0][7:0] sym_in, sym_out;
  logic [15:0]          lfsr_q;
  logic [LANE_WIDTH-1:0] data_q;
  logic [NSYM-1:0]      k_q;
  logic                 valid_q;

  assign sym_in        = data_in;
  assign lfsr_chain[0] = lfsr_q;

  // Symbol 0 is first in time, so the LFSR ripples upward through the word
  for (genvar g = 0; g < NSYM; g++) begin : g_sym
    pcie_scr_sym u_sym (
      .lfsr_i   (lfsr_chain[g]),
      .sym_i    (sym_in[g]),
      .k_i      (k_in[g]),
      .scr_en_i (scramble_en),
      .sym_o    (sym_out[g]),
      .lfsr_o   (lfsr_chain[g+1])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q  <= 16'hFFFF;
      data_q  <= '0;
      k_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_in;
      if (valid_in) begin
        lfsr_q <= lfsr_chain[NSYM];
        data_q <= sym_out;
        k_q    <= k_in;
      end
    end
  end

  assign data_out  = data_q;
  assign k_out     = k_q;
  assign valid_out = valid_q;
endmodule

// File: tb/tb_pcie_lane_scrambler.sv
// Bench for pcie_lane_scrambler: directed spec vectors plus random words checked
// against a model that indexes a precomputed keystream by bytes since last COM.

module tb_pcie_lane_scrambler;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data_in;
  logic [3:0]  k_in;
  logic        valid_in, scramble_en;
  logic [31:0] data_out;
  logic [3:0]  k_out;
  logic        valid_out;

  pcie_lane_scrambler #(.LANE_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .k_in(k_in),
    .valid_in(valid_in), .scramble_en(scramble_en),
    .data_out(data_out), .k_out(k_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  logic [7:0]  ks [0:4095];
  int          pos;
  logic [31:0] m_data;
  logic [3:0]  m_k;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic cyc(input logic [31:0] d, input logic [3:0] k, input logic v, input logic en);
    logic [31:0] e;
    logic [7:0]  s;
    @(negedge clk);
    data_in = d; k_in = k; valid_in = v; scramble_en = en;
    if (v) begin
      e = d;
      for (int j = 0; j < 4; j++) begin
        s = d[8*j +: 8];
        if (k[j]) begin
          if (s == 8'hBC) pos = 0;
          else if (s != 8'h1C) pos++;
        end else begin
          if (pos > 4095) begin
            chk("model_range", pos, 0);
            pos = 0;
          end
          if (en) e[8*j +: 8] = s ^ ks[pos];
          pos++;
        end
      end
      m_data = e;
      m_k    = k;
    end
    @(posedge clk); #1;
    chk("valid", 32'(valid_out), 32'(v));
    chk("data",  data_out, m_data);
    chk("k",     32'(k_out), 32'(m_k));
  endtask

  task automatic do_reset_state();
    pos = 0; m_data = '0; m_k = '0;
  endtask

  initial begin
    logic [15:0] l;
    logic [31:0] d;
    logic [3:0]  k;
    logic        en;
    logic [7:0]  kset [0:3];
    int          r;

    l = 16'hFFFF;
    for (int b = 0; b < 4096; b++) begin
      for (int i = 0; i < 8; i++) begin
        ks[b][i] = l[15];
        l = {l[14:0], 1'b0} ^ (l[15] ? 16'h0039 : 16'h0000);
      end
    end
    kset[0] = 8'hF7; kset[1] = 8'hFB; kset[2] = 8'hFD; kset[3] = 8'h7C;

    reset = 1'b1; data_in = '0; k_in = '0; valid_in = 1'b0; scramble_en = 1'b1;
    do_reset_state();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data",  data_out, 32'h0);
    chk("rst_k",     32'(k_out), 32'h0);
    chk("rst_valid", 32'(valid_out), 32'h0);
    @(negedge clk); reset = 1'b0;

    // zero-data keystream after COM
    cyc(32'h000000BC, 4'b0001, 1, 1); chk("t1_w1", data_out, 32'hC017FFBC);
    cyc(32'h0, 4'b0, 1, 1);          chk("t1_w2", data_out, 32'h02E7B214);
    cyc(32'h0, 4'b0, 1, 1);          chk("t1_w3", data_out, 32'h286E7282);
    cyc(32'h0, 4'b0, 1, 1);          chk("t1_w4", data_out, 32'hBF6DBEA6);
    cyc(32'h0, 4'b0, 1, 1);          chk("t1_w5b0", 32'(data_out[7:0]), 32'h8D);

    // SKP transparency
    cyc(32'h1C1C00BC, 4'b1101, 1, 1); chk("t2_w1", data_out, 32'h1C1CFFBC);
    chk("t2_k1", 32'(k_out), 32'hD);
    cyc(32'h0000001C, 4'b0001, 1, 1); chk("t2_w2", data_out, 32'h14C0171C);

    // bypass then resume
    cyc(32'hA5A5A5BC, 4'b0001, 0, 0);
    cyc(32'hA5A5A5BC, 4'b0001, 1, 0); chk("t3_w1", data_out, 32'hA5A5A5BC);
    cyc(32'h0, 4'b0, 1, 1);          chk("t3_w2", data_out, 32'h02E7B214);

    // valid gaps
    cyc(32'h000000BC, 4'b0001, 1, 1); chk("t4_w1", data_out, 32'hC017FFBC);
    repeat (3) begin
      cyc(32'hDEADBEEF, 4'b1010, 0, 1); chk("t4_hold", data_out, 32'hC017FFBC);
    end
    cyc(32'h0, 4'b0, 1, 1);          chk("t4_w2", data_out, 32'h02E7B214);
    repeat (3) cyc(32'h12345678, 4'b0, 0, 0);
    cyc(32'h0, 4'b0, 1, 1);          chk("t4_w3", data_out, 32'h286E7282);

    // reseed mid-word
    cyc(32'h000000BC, 4'b0001, 1, 1);
    repeat (5) cyc(32'h0, 4'b0, 1, 1);
    cyc(32'h00BC0000, 4'b0100, 1, 1);
    chk("t5_com", 32'(data_out[23:16]), 32'hBC);
    chk("t5_after", 32'(data_out[31:24]), 32'hFF);
    cyc(32'h0, 4'b0, 1, 1);          chk("t5_next", 32'(data_out[7:0]), 32'h17);

    // async reset between edges
    cyc(32'h0, 4'b0, 1, 1);
    valid_in = 1'b0;
    @(negedge clk); #2 reset = 1'b1; #1;
    chk("t6_data",  data_out, 32'h0);
    chk("t6_k",     32'(k_out), 32'h0);
    chk("t6_valid", 32'(valid_out), 32'h0);
    do_reset_state();
    @(posedge clk); #2 reset = 1'b0;
    cyc(32'h0, 4'b0, 1, 1);          chk("t6_first", 32'(data_out[7:0]), 32'hFF);

    // random words
    en = 1'b1;
    for (int it = 0; it < 400; it++) begin
      for (int j = 0; j < 4; j++) begin
        r = $urandom_range(0, 15);
        if (r == 0 || (j == 0 && it % 50 == 0)) begin d[8*j +: 8] = 8'hBC; k[j] = 1'b1; end
        else if (r == 1) begin d[8*j +: 8] = 8'h1C; k[j] = 1'b1; end
        else if (r == 2) begin d[8*j +: 8] = kset[$urandom_range(0, 3)]; k[j] = 1'b1; end
        else begin d[8*j +: 8] = 8'($urandom); k[j] = 1'b0; end
      end
      if ($urandom_range(0, 7) == 0) en = ~en;
      cyc(d, k, ($urandom_range(0, 3) != 0), en);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
